// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the MUSA stage sequencer: opcodes, stage encodings and opcode classes.
package stage_sequencer_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_ALU_05   = 6'b000101;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] OP_CTL_11   = 6'b010001;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_CTL_1D   = 6'b011101;
  localparam logic [5:0] OP_CALL     = 6'b000011;
  localparam logic [5:0] OP_RET      = 6'b000001;
  localparam logic [5:0] OP_HLT      = 6'b111111;

  typedef enum logic [2:0] {
    ST_IF     = 3'd0,
    ST_ID     = 3'd1,
    ST_EX     = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } stage_e;

  typedef enum logic [2:0] {
    CLS_ALU = 3'd0,
    CLS_LD  = 3'd1,
    CLS_ST  = 3'd2,
    CLS_CTL = 3'd3,
    CLS_HLT = 3'd4,
    CLS_NOP = 3'd5
  } op_class_e;

endpackage

// File: rtl/stage_sequencer_op_class_decode.sv
// Combinational opcode-to-class map; unlisted opcodes fall into the NOP class.
module op_class_decode
  import stage_sequencer_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic [2:0] op_class_o
);

  always_comb begin
    op_class_o = CLS_NOP;
    case (opcode_i)
      OP_RTYPE, OP_SPECIAL2, OP_ALU_05, OP_ADDI,
      OP_ADDIU, OP_ANDI, OP_ORI:                  op_class_o = CLS_ALU;
      OP_LW:                                      op_class_o = CLS_LD;
      OP_SW:                                      op_class_o = CLS_ST;
      OP_CTL_11, OP_J, OP_BEQ, OP_CTL_1D,
      OP_CALL, OP_RET:                            op_class_o = CLS_CTL;
      OP_HLT:                                     op_class_o = CLS_HLT;
      default:                                    op_class_o = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle stage FSM: walks each instruction through only the stages its class needs.
// Define STAGE_SEQ_TIMEOUT_EN to add the MEM-wait watchdog that halts the core on a stuck handshake.
module stage_sequencer
  import stage_sequencer_pkg::*;
`ifdef STAGE_SEQ_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int WAIT_CNT_W     = 4
)
`endif
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [2:0] stage,
  output logic       ir_write,
  output logic       pc_write,
  output logic       stack_strobe,
  output logic       mem_access,
  output logic       halted,
  output logic       mem_timeout
);

  stage_e     stage_q, stage_d;
  logic [5:0] op_q, op_d;
  logic [2:0] op_class_raw;
  op_class_e  op_cls;
  logic       timeout_hit;

  op_class_decode u_op_class_decode (
    .opcode_i   (op_q),
    .op_class_o (op_class_raw)
  );

  assign op_cls = op_class_e'(op_class_raw);

  always_comb begin
    // NOTE: defaults first so every path assigns stage_d/op_d and no latch is inferred.
    stage_d = stage_q;
    op_d    = op_q;
    unique case (stage_q)
      ST_IF: stage_d = ST_ID;
      ST_ID: begin
        op_d    = opcode;
        stage_d = (opcode == OP_HLT) ? ST_HALTED : ST_EX;
      end
      ST_EX: begin
        case (op_cls)
          CLS_LD, CLS_ST: stage_d = ST_MEM;
          CLS_ALU:        stage_d = ST_WB;
          default:        stage_d = ST_IF;
        endcase
      end
      ST_MEM: begin
        if (timeout_hit)    stage_d = ST_HALTED;
        else if (mem_ready) stage_d = (op_cls == CLS_LD) ? ST_WB : ST_IF;
      end
      ST_WB:     stage_d = ST_IF;
      ST_HALTED: stage_d = ST_HALTED;
      default:   stage_d = ST_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (reset) begin
      stage_q <= ST_IF;
      op_q    <= '0;
    end else begin
      stage_q <= stage_d;
      op_q    <= op_d;
    end
  end

`ifdef STAGE_SEQ_TIMEOUT_EN
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  mem_timeout_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive stalled MEM cycle.
  assign timeout_hit = (stage_q == ST_MEM) && !mem_ready &&
                       (wait_cnt_q == WAIT_CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (stage_q != ST_MEM)                   wait_cnt_d = '0;
    else if (!mem_ready && wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_q | timeout_hit;
    end
  end

  assign mem_timeout = mem_timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_timeout = 1'b0;
`endif

  // Strobes are held low while reset is asserted, even though stage_q still shows the old stage.
  assign stage        = stage_q;
  assign ir_write     = !reset && (stage_q == ST_IF);
  assign pc_write     = !reset && ((stage_q == ST_WB) ||
                                   (stage_q == ST_EX  && (op_cls == CLS_CTL || op_cls == CLS_NOP)) ||
                                   (stage_q == ST_MEM && mem_ready && op_cls == CLS_ST));
  assign stack_strobe = !reset && (stage_q == ST_EX) && (op_q == OP_CALL || op_q == OP_RET);
  assign mem_access   = !reset && (stage_q == ST_MEM);
  assign halted       = (stage_q == ST_HALTED);

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: a per-instruction stage-list model feeds expected cycles to a monitor.
module tb_stage_sequencer;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [2:0] stage;
  logic       ir_write, pc_write, stack_strobe, mem_access, halted, mem_timeout;

  stage_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .stage        (stage),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .stack_strobe (stack_strobe),
    .mem_access   (mem_access),
    .halted       (halted),
    .mem_timeout  (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] stage;
    logic       ir, pc, stk, mem, hlt, tmo;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic model_tmo = 1'b0;

  localparam logic [5:0] ALU_OPS [7] = '{6'b000000, 6'b011100, 6'b000101, 6'b001000,
                                         6'b001001, 6'b001100, 6'b001101};
  localparam logic [5:0] CTL_OPS [6] = '{6'b010001, 6'b000010, 6'b000100, 6'b011101,
                                         6'b000011, 6'b000001};
  localparam logic [5:0] ALL_OPS [16] = '{6'b000000, 6'b011100, 6'b000101, 6'b001000,
                                          6'b001001, 6'b001100, 6'b001101, 6'b100011,
                                          6'b101011, 6'b010001, 6'b000010, 6'b000100,
                                          6'b011101, 6'b000011, 6'b000001, 6'b111111};

  // 0=ALU 1=LD 2=ST 3=CTL 4=HLT 5=NOP
  function automatic int cls_of(input logic [5:0] op);
    foreach (ALU_OPS[i]) if (op == ALU_OPS[i]) return 0;
    foreach (CTL_OPS[i]) if (op == CTL_OPS[i]) return 3;
    if (op == 6'b100011) return 1;
    if (op == 6'b101011) return 2;
    if (op == 6'b111111) return 4;
    return 5;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("stage",        8'(stage),        8'(mon_e.stage));
      check("ir_write",     8'(ir_write),     8'(mon_e.ir));
      check("pc_write",     8'(pc_write),     8'(mon_e.pc));
      check("stack_strobe", 8'(stack_strobe), 8'(mon_e.stk));
      check("mem_access",   8'(mem_access),   8'(mon_e.mem));
      check("halted",       8'(halted),       8'(mon_e.hlt));
      check("mem_timeout",  8'(mem_timeout),  8'(mon_e.tmo));
    end
  end

  // Drive one cycle and queue what the outputs must be during it.
  task automatic step(input logic [5:0] op, input logic rdy, input logic rst,
                      input int s, input logic last, input logic [5:0] inst_op);
    exp_t e;
    opcode    = op;
    mem_ready = rdy;
    reset     = rst;
    e.stage = 3'(s);
    e.ir    = !rst && (s == 0);
    e.pc    = !rst && last;
    e.stk   = !rst && (s == 2) && (inst_op == 6'b000011 || inst_op == 6'b000001);
    e.mem   = !rst && (s == 3);
    e.hlt   = (s == 5);
    e.tmo   = model_tmo;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    if (rst) model_tmo = 1'b0;
  endtask

  // Builds the instruction's stage list from its class, then plays it cycle by cycle.
  task automatic run_instr(input logic [5:0] inst_op, input int w, input int abort_at, input int hold);
    int   seq[$];
    int   c;
    int   mem_i;
    logic halts;
    logic tmo_case;
    logic [5:0] drv;
    logic rdy;
    c        = cls_of(inst_op);
    halts    = (c == 4);
    tmo_case = 1'b0;
    seq.push_back(0);
    seq.push_back(1);
    if (!halts) seq.push_back(2);
    if (c == 1 || c == 2) begin
`ifdef STAGE_SEQ_TIMEOUT_EN
      if (w >= 15) begin
        repeat (15) seq.push_back(3);
        halts    = 1'b1;
        tmo_case = 1'b1;
      end else
`endif
      repeat (w + 1) seq.push_back(3);
    end
    if (!halts && (c == 0 || c == 1)) seq.push_back(4);
    mem_i = 0;
    foreach (seq[i]) begin
      drv = (seq[i] == 1) ? inst_op : 6'($urandom);
      if (seq[i] == 3) begin
        rdy = (mem_i == w);
        mem_i++;
      end else begin
        rdy = 1'($urandom);
      end
      if (i == abort_at) begin
        step(drv, rdy, 1'b1, seq[i], 1'b0, inst_op);
        step(6'($urandom), 1'($urandom), 1'b1, 0, 1'b0, inst_op);
        return;
      end
      step(drv, rdy, 1'b0, seq[i], !halts && (i == seq.size() - 1), inst_op);
    end
    if (halts) begin
      if (tmo_case) model_tmo = 1'b1;
      repeat (hold) step(6'($urandom), 1'($urandom), 1'b0, 5, 1'b0, inst_op);
      step(6'($urandom), 1'($urandom), 1'b1, 5, 1'b0, inst_op);
      step(6'($urandom), 1'($urandom), 1'b1, 0, 1'b0, inst_op);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [5:0] op;
    reset     = 1'b1;
    opcode    = 6'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step(6'b0, 1'b0, 1'b1, 0, 1'b0, 6'b0);

    run_instr(6'b001000, 0, -1, 0);   // ADDI: IF ID EX WB
    run_instr(6'b100011, 3, -1, 0);   // LW with three stalled MEM cycles
    run_instr(6'b000011, 0, -1, 0);   // CALL
    run_instr(6'b000001, 0, -1, 0);   // RET
    run_instr(6'b111111, 0, -1, 20);  // HLT, then reset
    run_instr(6'b101011, 6, 5, 0);    // SW, reset during the third MEM wait
    run_instr(6'b100011, 20, -1, 5);  // LW long stall (times out only with the watchdog)
    run_instr(6'b101011, 0, -1, 0);   // SW completing at once

    repeat (80) begin
      if ($urandom_range(3) == 0) op = 6'($urandom);
      else                        op = ALL_OPS[$urandom_range(15)];
      run_instr(op, int'($urandom_range(4)),
                ($urandom_range(7) == 0) ? int'($urandom_range(8)) : -1,
                int'($urandom_range(6, 1)));
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
